// File: rtl/viterbi_job_ctrl_if.sv
// Signal bundle between the job source, the Viterbi core and the path sink.
// The controller takes the slave view; a job source / core model takes the master view.
interface viterbi_job_ctrl_if #(
    parameter int I = 3,
    parameter int K = 3,
    parameter int N = 5
);
    localparam int SW  = $clog2(I);
    localparam int OW  = $clog2(K);
    localparam int LW  = $clog2(N + 1);
    localparam int CLW = $clog2(N);

    logic              job_valid;
    logic              job_ready;
    logic [LW-1:0]     job_len;
    logic              obs_valid;
    logic              obs_ready;
    logic [OW-1:0]     obs_data;
    logic              core_start;
    logic [CLW-1:0]    core_length;
    logic [OW-1:0]     core_obs_in;
    logic              core_obs_valid;
    logic [N*SW-1:0]   core_path;
    logic              core_done;
    logic              out_valid;
    logic              out_ready;
    logic [SW-1:0]     out_state;
    logic              out_last;
    logic              busy;
    logic              err;

    modport slave (
        input  job_valid, job_len, obs_valid, obs_data, core_path, core_done, out_ready,
        output job_ready, obs_ready, core_start, core_length, core_obs_in, core_obs_valid,
               out_valid, out_state, out_last, busy, err
    );

    modport master (
        output job_valid, job_len, obs_valid, obs_data, core_path, core_done, out_ready,
        input  job_ready, obs_ready, core_start, core_length, core_obs_in, core_obs_valid,
               out_valid, out_state, out_last, busy, err
    );
endinterface

// File: rtl/viterbi_job_ctrl.sv
// Job sequencer for the Viterbi core: buffers observations, streams them to the core
// without gaps, waits for done with a timeout, then returns the decoded path beat by beat.
module viterbi_job_ctrl #(
    parameter int I   = 3,
    parameter int K   = 3,
    parameter int N   = 5,
    parameter int TMO = 256
) (
    input  logic                clk,
    input  logic                rst_n,
    viterbi_job_ctrl_if.slave   bus
);
    localparam int SW  = $clog2(I);
    localparam int OW  = $clog2(K);
    localparam int LW  = $clog2(N + 1);
    localparam int CLW = $clog2(N);
    localparam int CW  = (TMO > 1) ? $clog2(TMO) : 1;

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_KICK, S_STREAM, S_WAIT, S_SETTLE, S_DRAIN
    } state_t;

    state_t          state, state_nxt;
    logic [LW-1:0]   len;
    logic [LW-1:0]   idx;
    logic [CW-1:0]   cnt;
    logic            err_q;
    logic [OW-1:0]   obs_buf  [N];
    logic [SW-1:0]   path_buf [N];

    logic job_fire, len_ok, obs_fire, out_fire, idx_last, tmo_hit;

    assign job_fire = bus.job_valid && (state == S_IDLE);
    assign len_ok   = (bus.job_len != '0) && (bus.job_len <= LW'(N));
    assign obs_fire = bus.obs_valid && (state == S_LOAD);
    assign out_fire = bus.out_ready && (state == S_DRAIN);
    assign idx_last = (idx == len - LW'(1));
    assign tmo_hit  = (cnt == CW'(TMO - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    // NOTE: every variable written in always_comb gets a default first, so no path can infer a latch.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (job_fire && len_ok) state_nxt = S_LOAD;
            S_LOAD:   if (obs_fire && idx_last) state_nxt = S_KICK;
            S_KICK:   state_nxt = S_STREAM;
            S_STREAM: if (idx_last) state_nxt = S_WAIT;
            S_WAIT: begin
                // done has priority over a timeout landing on the same cycle
                if (bus.core_done)  state_nxt = S_SETTLE;
                else if (tmo_hit)   state_nxt = S_IDLE;
            end
            S_SETTLE: state_nxt = S_DRAIN;
            S_DRAIN:  if (out_fire && idx_last) state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            len   <= '0;
            idx   <= '0;
            cnt   <= '0;
            err_q <= 1'b0;
        end else begin
            err_q <= 1'b0;
            case (state)
                S_IDLE: if (job_fire) begin
                    len   <= bus.job_len;
                    err_q <= !len_ok;
                end
                S_LOAD:   if (obs_fire) idx <= idx_last ? '0 : idx + LW'(1);
                S_STREAM: begin
                    idx <= idx_last ? '0 : idx + LW'(1);
                    cnt <= '0;
                end
                S_WAIT: if (!bus.core_done) begin
                    if (tmo_hit) err_q <= 1'b1;
                    else         cnt   <= cnt + CW'(1);
                end
                S_SETTLE: idx <= '0;
                S_DRAIN:  if (out_fire) idx <= idx_last ? '0 : idx + LW'(1);
                default: ;
            endcase
        end
    end

    // NOTE: the buffers are plain storage with no reset; every entry is written before it is read.
    always_ff @(posedge clk) begin
        if (obs_fire) obs_buf[idx] <= bus.obs_data;
        // the core writes path[0] one cycle after done, so capture at the end of SETTLE
        if (state == S_SETTLE) begin
            for (int j = 0; j < N; j++) path_buf[j] <= bus.core_path[j*SW +: SW];
        end
    end

    assign bus.job_ready      = (state == S_IDLE);
    assign bus.obs_ready      = (state == S_LOAD);
    assign bus.core_start     = (state == S_KICK);
    assign bus.core_length    = len[CLW-1:0];
    assign bus.core_obs_valid = (state == S_STREAM);
    assign bus.core_obs_in    = (state == S_STREAM) ? obs_buf[idx] : '0;
    assign bus.out_valid      = (state == S_DRAIN);
    assign bus.out_state      = (state == S_DRAIN) ? path_buf[idx] : '0;
    assign bus.out_last       = (state == S_DRAIN) && idx_last;
    assign bus.busy           = (state != S_IDLE);
    assign bus.err            = err_q;
endmodule

// File: tb/tb_viterbi_job_ctrl.sv
// Scoreboard bench for viterbi_job_ctrl: a core model checks the observation stream and
// supplies a random path, whose expected beats are queued and compared at the output.
module tb_viterbi_job_ctrl;
    localparam int N   = 5;
    localparam int SW  = 2;
    localparam int TMO = 16;

    typedef struct {
        logic [SW-1:0] st;
        logic          last;
    } beat_t;

    logic clk = 1'b0;
    logic rst_n;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    logic [1:0] exp_obs[$];
    beat_t      exp_path[$];

    int cur_len, start_cnt, done_cyc, wait_cyc, delivered, valid_cycles, rdy_mode;
    bit core_en;

    int kick_len, beats, first_cyc, core_wait;
    bit path_pending;
    logic [N*SW-1:0] next_path;

    bit prev_valid, prev_stall, prev_last, last_hs;
    logic [SW-1:0] prev_state;
    beat_t b;

    logic [1:0] nom_obs [5];

    viterbi_job_ctrl_if #(.I(3), .K(3), .N(N)) bus ();

    viterbi_job_ctrl #(.I(3), .K(3), .N(N), .TMO(TMO)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_job(input logic [2:0] len);
        int t;
        t = 0;
        bus.job_valid = 1'b1;
        bus.job_len   = len;
        @(negedge clk);
        while (!bus.job_ready && t < 300) begin
            @(negedge clk);
            t++;
        end
        check("job_accept", 32'(bus.job_ready), 32'd1);
        cur_len = int'(len);
        @(posedge clk);
        #1;
        bus.job_valid = 1'b0;
    endtask

    task automatic send_obs(input logic [1:0] d);
        int t;
        t = 0;
        bus.obs_valid = 1'b1;
        bus.obs_data  = d;
        @(negedge clk);
        while (!bus.obs_ready && t < 300) begin
            @(negedge clk);
            t++;
        end
        check("obs_accept", 32'(bus.obs_ready), 32'd1);
        exp_obs.push_back(d);
        @(posedge clk);
        #1;
        bus.obs_valid = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int t;
        t = 0;
        @(negedge clk);
        while (bus.busy && t < 300) begin
            @(negedge clk);
            t++;
        end
        check(tag, 32'(bus.busy), 32'd0);
        @(posedge clk);
        #1;
    endtask

    // core model: checks the start pulse and the observation stream, raises done 7 cycles
    // after the last observation and presents a fresh random path one cycle after done
    initial begin : core_model
        bus.core_done = 1'b0;
        bus.core_path = '0;
        kick_len = 0;
        beats = 0;
        core_wait = 0;
        path_pending = 1'b0;
        forever begin
            @(negedge clk);
            bus.core_done = 1'b0;
            if (!rst_n) begin
                kick_len = 0;
                beats = 0;
                core_wait = 0;
                path_pending = 1'b0;
                exp_obs.delete();
            end else begin
                if (path_pending) begin
                    bus.core_path = next_path;
                    path_pending = 1'b0;
                end
                if (bus.core_start) begin
                    start_cnt++;
                    check("core_length", 32'(bus.core_length), 32'(cur_len));
                    kick_len = cur_len;
                    beats = 0;
                end
                if (bus.core_obs_valid) begin
                    if (exp_obs.size() == 0) check("obs_extra", 32'd1, 32'd0);
                    else check("core_obs_in", 32'(bus.core_obs_in), 32'(exp_obs.pop_front()));
                    if (beats == 0) first_cyc = cyc;
                    beats++;
                    if (beats == kick_len) begin
                        check("stream_span", 32'(cyc - first_cyc + 1), 32'(kick_len));
                        wait_cyc = cyc + 1;
                        if (core_en) core_wait = 7;
                    end
                end else if (core_wait > 0) begin
                    core_wait--;
                    if (core_wait == 0) begin
                        bus.core_done = 1'b1;
                        done_cyc = cyc;
                        for (int j = 0; j < N; j++) next_path[j*SW +: SW] = 2'($urandom_range(0, 2));
                        for (int j = 0; j < kick_len; j++)
                            exp_path.push_back('{st: next_path[j*SW +: SW], last: (j == kick_len - 1)});
                        path_pending = 1'b1;
                    end
                end
            end
        end
    end

    initial begin : ready_driver
        int k;
        k = 0;
        bus.out_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (rdy_mode == 0) begin
                bus.out_ready = 1'b1;
            end else begin
                bus.out_ready = (k % 3 == 0);
                k++;
            end
        end
    end

    initial begin : out_monitor
        prev_valid = 1'b0;
        prev_stall = 1'b0;
        last_hs = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_valid = 1'b0;
                prev_stall = 1'b0;
                last_hs = 1'b0;
            end else begin
                if (last_hs) check("job_ready_after_last", 32'(bus.job_ready), 32'd1);
                last_hs = 1'b0;
                if (bus.out_valid) valid_cycles++;
                if (bus.out_valid && !prev_valid) check("done_to_valid", 32'(cyc - done_cyc), 32'd2);
                if (bus.out_valid && prev_stall) begin
                    check("stall_state", 32'(bus.out_state), 32'(prev_state));
                    check("stall_last", 32'(bus.out_last), 32'(prev_last));
                end
                if (bus.out_valid && bus.out_ready) begin
                    if (exp_path.size() == 0) begin
                        check("beat_extra", 32'd1, 32'd0);
                    end else begin
                        b = exp_path.pop_front();
                        check("out_state", 32'(bus.out_state), 32'(b.st));
                        check("out_last", 32'(bus.out_last), 32'(b.last));
                        last_hs = b.last;
                    end
                    delivered++;
                end
                prev_valid = bus.out_valid;
                prev_stall = bus.out_valid && !bus.out_ready;
                prev_state = bus.out_state;
                prev_last  = bus.out_last;
            end
        end
    end

    initial begin : watchdog
        #300000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        int s0, d0, v0, t;
        nom_obs = '{2'd0, 2'd1, 2'd2, 2'd0, 2'd1};
        cur_len = 0; start_cnt = 0; done_cyc = 0; wait_cyc = 0;
        delivered = 0; valid_cycles = 0; rdy_mode = 0; core_en = 1'b1;
        rst_n = 1'b0;
        bus.job_valid = 1'b0;
        bus.job_len   = '0;
        bus.obs_valid = 1'b0;
        bus.obs_data  = '0;

        // reset state
        repeat (3) @(negedge clk);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_core_start", 32'(bus.core_start), 32'd0);
        check("rst_core_obs_valid", 32'(bus.core_obs_valid), 32'd0);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_err", 32'(bus.err), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_job_ready", 32'(bus.job_ready), 32'd1);
        @(posedge clk);
        #1;

        // nominal len=5, no stalls
        s0 = start_cnt; d0 = delivered;
        send_job(3'd5);
        for (int i = 0; i < 5; i++) send_obs(nom_obs[i]);
        wait_idle("nominal_idle");
        check("nominal_starts", 32'(start_cnt - s0), 32'd1);
        check("nominal_beats", 32'(delivered - d0), 32'd5);
        check("nominal_obs_left", 32'(exp_obs.size()), 32'd0);
        check("nominal_path_left", 32'(exp_path.size()), 32'd0);

        // bubbly input and output backpressure, len=3
        rdy_mode = 1;
        d0 = delivered;
        send_job(3'd3);
        for (int i = 0; i < 3; i++) begin
            send_obs(2'((i + 2) % 3));
            idle(2);
        end
        wait_idle("bubbly_idle");
        check("bubbly_beats", 32'(delivered - d0), 32'd3);
        check("bubbly_path_left", 32'(exp_path.size()), 32'd0);
        rdy_mode = 0;

        // illegal lengths 0 and 6
        for (int i = 0; i < 2; i++) begin
            s0 = start_cnt;
            send_job((i == 0) ? 3'd0 : 3'd6);
            @(negedge clk);
            check("illegal_err", 32'(bus.err), 32'd1);
            check("illegal_busy", 32'(bus.busy), 32'd0);
            @(negedge clk);
            check("illegal_err_pulse", 32'(bus.err), 32'd0);
            check("illegal_busy2", 32'(bus.busy), 32'd0);
            check("illegal_no_start", 32'(start_cnt - s0), 32'd0);
            @(posedge clk);
            #1;
        end

        // timeout: core never signals done
        core_en = 1'b0;
        v0 = valid_cycles;
        send_job(3'd2);
        send_obs(2'd1);
        send_obs(2'd2);
        t = 0;
        @(negedge clk);
        while (!bus.err && t < 200) begin
            @(negedge clk);
            t++;
        end
        check("tmo_delay", 32'(cyc - wait_cyc), 32'(TMO));
        check("tmo_busy", 32'(bus.busy), 32'd0);
        @(negedge clk);
        check("tmo_err_pulse", 32'(bus.err), 32'd0);
        check("tmo_no_valid", 32'(valid_cycles - v0), 32'd0);
        core_en = 1'b1;
        @(posedge clk);
        #1;

        // reset during stream beat 2, then a fresh len=2 job
        send_job(3'd5);
        send_obs(2'd2); send_obs(2'd2); send_obs(2'd1); send_obs(2'd0); send_obs(2'd1);
        t = 0;
        @(negedge clk);
        while (!bus.core_obs_valid && t < 50) begin
            @(negedge clk);
            t++;
        end
        check("mid_stream_seen", 32'(bus.core_obs_valid), 32'd1);
        idle(2);
        rst_n = 1'b0;
        #1;
        check("mid_rst_obs_valid", 32'(bus.core_obs_valid), 32'd0);
        check("mid_rst_core_start", 32'(bus.core_start), 32'd0);
        check("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("mid_rst_err", 32'(bus.err), 32'd0);
        check("mid_rst_busy", 32'(bus.busy), 32'd0);
        idle(2);
        rst_n = 1'b1;
        idle(1);
        d0 = delivered;
        send_job(3'd2);
        send_obs(2'd1);
        send_obs(2'd0);
        wait_idle("post_rst_idle");
        check("post_rst_beats", 32'(delivered - d0), 32'd2);

        // back-to-back len=5 jobs
        d0 = delivered;
        send_job(3'd5);
        for (int i = 0; i < 5; i++) send_obs(2'((i + 1) % 3));
        send_job(3'd5);
        for (int i = 0; i < 5; i++) send_obs(2'(2 - (i % 3)));
        wait_idle("b2b_idle");
        check("b2b_beats", 32'(delivered - d0), 32'd10);
        check("b2b_obs_left", 32'(exp_obs.size()), 32'd0);
        check("b2b_path_left", 32'(exp_path.size()), 32'd0);

        idle(2);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
